// File: rtl/video_timing_pkg.sv
// Shared raster timing defaults and types for the video pipeline blocks.
package video_timing_pkg;

    localparam int DEF_H_ACTIVE = 256;
    localparam int DEF_H_TOTAL  = 320;
    localparam int DEF_HS_START = 272;
    localparam int DEF_HS_END   = 296;
    localparam int DEF_V_ACTIVE = 240;
    localparam int DEF_V_TOTAL  = 262;
    localparam int DEF_VS_START = 244;
    localparam int DEF_VS_END   = 247;

    localparam int FB_SIZE = DEF_H_ACTIVE * DEF_V_ACTIVE;

    typedef struct packed {
        logic hs;
        logic vs;
        logic hb;
        logic vb;
    } timing_flags_t;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters gated by a pixel enable, with the next
// position exposed so downstream stages can prepare one tick ahead.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int HS_START = DEF_HS_START,
    parameter int HS_END   = DEF_HS_END,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int VS_START = DEF_VS_START,
    parameter int VS_END   = DEF_VS_END,
    parameter int HW       = $clog2(H_TOTAL),
    parameter int VW       = $clog2(V_TOTAL)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce_pix,
    output logic [HW-1:0] h_next,
    output logic [VW-1:0] v_next,
    output timing_flags_t flags,
    output logic          frame_start
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_S   = HW'(HS_START);
    localparam logic [HW-1:0] HS_E   = HW'(HS_END);
    localparam logic [VW-1:0] VS_S   = VW'(VS_START);
    localparam logic [VW-1:0] VS_E   = VW'(VS_END);

    logic [HW-1:0] h_reg;
    logic [VW-1:0] v_reg;
    logic          frame_start_reg;

    always_comb begin
        h_next = h_reg + 1'b1;
        v_next = v_reg;
        if (h_reg == H_LAST) begin
            h_next = '0;
            v_next = (v_reg == V_LAST) ? '0 : v_reg + 1'b1;
        end
    end

    // Flags describe the position currently held by the counters.
    assign flags.hs = (h_reg >= HS_S) && (h_reg < HS_E);
    assign flags.vs = (v_reg >= VS_S) && (v_reg < VS_E);
    assign flags.hb = (h_reg >= H_ACT);
    assign flags.vb = (v_reg >= V_ACT);

    always_ff @(posedge clock) begin
        if (reset) begin
            h_reg           <= '0;
            v_reg           <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= 1'b0;
            if (ce_pix) begin
                h_reg           <= h_next;
                v_reg           <= v_next;
                frame_start_reg <= (h_next == '0) && (v_next == '0);
            end
        end
    end

    assign frame_start = frame_start_reg;

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: walks the displayed half of a double-buffered dpram and
// returns pixels aligned with sync/blank, swapping halves at vblank on request.
module fb_scanout
    import video_timing_pkg::*;
#(
    parameter int addr_width_g = $clog2(2 * FB_SIZE),
    parameter int data_width_g = 8,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int HS_START     = DEF_HS_START,
    parameter int HS_END       = DEF_HS_END,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int VS_START     = DEF_VS_START,
    parameter int VS_END       = DEF_VS_END
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ce_pix,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    disp_sel,
    output logic [addr_width_g-1:0] ram_addr,
    input  logic [data_width_g-1:0] ram_q,
    output logic [data_width_g-1:0] pixel,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    hblank,
    output logic                    vblank,
    output logic                    frame_start
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [addr_width_g-1:0] BUF1_BASE = addr_width_g'(H_ACTIVE * V_ACTIVE);
    localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);

    logic [HW-1:0]           h_next;
    logic [VW-1:0]           v_next;
    timing_flags_t           flags;
    swap_state_t             swap_state_reg;
    logic                    disp_sel_reg;
    logic                    swap_ack_reg;
    logic [addr_width_g-1:0] ram_addr_reg;
    logic [data_width_g-1:0] pixel_reg;
    timing_flags_t           sync_reg;
    logic                    at_frame_origin;
    logic                    at_swap_point;
    logic                    next_active;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .HS_START (HS_START),
        .HS_END   (HS_END),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL),
        .VS_START (VS_START),
        .VS_END   (VS_END),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clock       (clock),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .h_next      (h_next),
        .v_next      (v_next),
        .flags       (flags),
        .frame_start (frame_start)
    );

    assign at_frame_origin = (h_next == '0) && (v_next == '0);
    assign at_swap_point   = (h_next == '0) && (v_next == V_ACT);
    assign next_active     = (h_next < H_ACT) && (v_next < V_ACT);

    // Swap only on entry to vblank, so the displayed half never changes mid-picture.
    always_ff @(posedge clock) begin
        if (reset) begin
            swap_state_reg <= SWAP_IDLE;
            disp_sel_reg   <= 1'b0;
            swap_ack_reg   <= 1'b0;
        end else begin
            swap_ack_reg <= 1'b0;
            if (ce_pix && at_swap_point && (swap_state_reg == SWAP_PENDING || swap_req)) begin
                disp_sel_reg   <= ~disp_sel_reg;
                swap_ack_reg   <= 1'b1;
                swap_state_reg <= SWAP_IDLE;
            end else if (swap_req) begin
                swap_state_reg <= SWAP_PENDING;
            end
        end
    end

    // Address leads the outputs by one tick to cover the dpram read latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_addr_reg <= '0;
            pixel_reg    <= '0;
            sync_reg     <= '{hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1};
        end else if (ce_pix) begin
            if (at_frame_origin) begin
                ram_addr_reg <= disp_sel_reg ? BUF1_BASE : '0;
            end else if (next_active) begin
                ram_addr_reg <= ram_addr_reg + 1'b1;
            end
            sync_reg  <= flags;
            pixel_reg <= (flags.hb || flags.vb) ? '0 : ram_q;
        end
    end

    assign swap_ack = swap_ack_reg;
    assign disp_sel = disp_sel_reg;
    assign ram_addr = ram_addr_reg;
    assign pixel    = pixel_reg;
    assign hsync    = sync_reg.hs;
    assign vsync    = sync_reg.vs;
    assign hblank   = sync_reg.hb;
    assign vblank   = sync_reg.vb;

endmodule
